// File: rtl/prog_sequencer.sv
// prog_sequencer: multi-cycle control sequencer for the 9-bit core.
// Drives PC / IR / register-file / data-memory strobes from the decoder
// controls, owns the host Start/Done handshake and the data-memory
// request/ready handshake with a bounded wait (MEM_TIMEOUT cycles).
// Optional performance counters (CycleCnt, InstCnt) are built only when
// the macro PROG_SEQ_PERF_CNT_EN is defined.
module prog_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic             BranchEn,
  input  logic             Jump,
  input  logic             RegWrEn,
  input  logic             MemWrEn,
  input  logic             LoadInst,
  input  logic             Ack,
  input  logic             BranchTaken,
  input  logic             MemReady,
  output logic             PCClr,
  output logic             PCEn,
  output logic             PCLoad,
  output logic             PCSel,
  output logic             IRLoad,
  output logic             RegWrStrobe,
  output logic             MemReq,
  output logic             MemWe,
  output logic             Done,
  output logic             Err,
  output logic [2:0]       State
`ifdef PROG_SEQ_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] CycleCnt,
  output logic [CNT_W-1:0] InstCnt
`endif
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_MEM   = 3'd3,
    ST_WB    = 3'd4,
    ST_HALT  = 3'd5,
    ST_ERROR = 3'd6
  } state_t;

  if (MEM_TIMEOUT < 1 || MEM_TIMEOUT > 255 || CNT_W < 1) begin : g_bad_param
    $error("prog_sequencer: MEM_TIMEOUT must be 1..255 and CNT_W >= 1");
  end

  localparam logic [7:0] TO_MAX  = 8'(MEM_TIMEOUT);
  // Timeout fires in the MEM cycle whose miss would bring the count to
  // MEM_TIMEOUT, so the request is held for exactly MEM_TIMEOUT cycles.
  localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_wait_cnt;
  logic       r_mem_we;
  logic       r_done;
  logic       r_err;

  // Next-state and per-cycle strobe decode
  always_comb begin
    w_next      = r_state;
    PCClr       = 1'b0;
    PCEn        = 1'b0;
    PCLoad      = 1'b0;
    PCSel       = 1'b0;
    IRLoad      = 1'b0;
    RegWrStrobe = 1'b0;
    MemReq      = 1'b0;
    MemWe       = 1'b0;
    case (r_state)
      ST_IDLE, ST_HALT, ST_ERROR: begin
        if (Start) begin
          PCClr  = 1'b1;
          w_next = ST_FETCH;
        end
      end
      ST_FETCH: begin
        IRLoad = 1'b1;
        w_next = ST_EXEC;
      end
      ST_EXEC: begin
        if (Ack) begin
          w_next = ST_HALT;
        end else if (LoadInst) begin
          MemReq = 1'b1;
          MemWe  = 1'b0;
          w_next = ST_MEM;
        end else if (MemWrEn) begin
          MemReq = 1'b1;
          MemWe  = 1'b1;
          w_next = ST_MEM;
        end else begin
          RegWrStrobe = RegWrEn;
          PCEn        = 1'b1;
          if (BranchEn && BranchTaken) begin
            PCLoad = 1'b1;
            PCSel  = Jump;
          end
          w_next = ST_FETCH;
        end
      end
      ST_MEM: begin
        MemReq = 1'b1;
        MemWe  = r_mem_we;
        if (MemReady) begin
          if (r_mem_we) begin
            PCEn   = 1'b1;
            w_next = ST_FETCH;
          end else begin
            w_next = ST_WB;
          end
        end else if (r_wait_cnt >= TO_LAST) begin
          w_next = ST_ERROR;
        end
      end
      ST_WB: begin
        RegWrStrobe = 1'b1;
        PCEn        = 1'b1;
        w_next      = ST_FETCH;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // State register plus registered Done/Err flags
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= ST_IDLE;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= (w_next == ST_HALT);
      r_err   <= (w_next == ST_ERROR);
    end
  end

  // Memory access direction latch and saturating wait counter
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_wait_cnt <= '0;
      r_mem_we   <= 1'b0;
    end else if (r_state == ST_EXEC) begin
      r_wait_cnt <= '0;
      r_mem_we   <= !LoadInst;
    end else if (r_state == ST_MEM && !MemReady && r_wait_cnt != TO_MAX) begin
      r_wait_cnt <= r_wait_cnt + 8'd1;
    end
  end

  assign Done  = r_done;
  assign Err   = r_err;
  assign State = r_state;

`ifdef PROG_SEQ_PERF_CNT_EN
  logic [CNT_W-1:0] r_cycle_cnt;
  logic [CNT_W-1:0] r_inst_cnt;
  logic             w_busy;
  logic             w_retire;

  // Busy-cycle and retirement qualifiers
  always_comb begin
    w_busy   = (r_state == ST_FETCH) || (r_state == ST_EXEC) ||
               (r_state == ST_MEM)   || (r_state == ST_WB);
    w_retire = ((r_state == ST_EXEC) && (w_next == ST_FETCH || w_next == ST_HALT)) ||
               ((r_state == ST_MEM)  && (w_next == ST_FETCH)) ||
               (r_state == ST_WB);
  end

  // Saturating performance counters, cleared by an accepted Start
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_cycle_cnt <= '0;
      r_inst_cnt  <= '0;
    end else if (PCClr) begin
      r_cycle_cnt <= '0;
      r_inst_cnt  <= '0;
    end else begin
      if (w_busy && r_cycle_cnt != '1) r_cycle_cnt <= r_cycle_cnt + 1'b1;
      if (w_retire && r_inst_cnt != '1) r_inst_cnt <= r_inst_cnt + 1'b1;
    end
  end

  assign CycleCnt = r_cycle_cnt;
  assign InstCnt  = r_inst_cnt;
`endif

endmodule

// File: doc/prog_sequencer.md
Name: prog_sequencer

Overview:
- Multi-cycle control sequencer for the 9-bit core.
- Consumes the instruction decoder's control outputs (BranchEn, Jump, RegWrEn, MemWrEn, LoadInst, Ack) and generates per-cycle strobes for the PC, instruction register, register file and data memory.
- Owns the Start/Done program handshake with the host.
- Owns the data-memory request/ready handshake, including a timeout.

Parameters:
MEM_TIMEOUT, 15, max cycles MemReq may wait for MemReady before error (1..255)
CNT_W, 16, width of performance counters (used only with the optional feature)

Ports:
Clk  input  1  clock, rising edge
Reset_n  input  1  asynchronous active-low reset
Start  input  1  host pulse: begin program at PC 0
BranchEn  input  1  decoder: branch instruction
Jump  input  1  decoder: LUT (1) or relative (0) target
RegWrEn  input  1  decoder: instruction writes reg file
MemWrEn  input  1  decoder: store
LoadInst  input  1  decoder: load
Ack  input  1  decoder: end-of-program instruction
BranchTaken  input  1  ALU flag: branch condition true
MemReady  input  1  data memory: access complete this cycle
PCClr  output  1  force PC to 0
PCEn  output  1  advance PC this cycle
PCLoad  output  1  load branch target (with PCEn)
PCSel  output  1  target source; equals Jump when PCLoad=1, else 0
IRLoad  output  1  capture instruction ROM output
RegWrStrobe  output  1  commit register-file write
MemReq  output  1  data memory request
MemWe  output  1  request is a write
Done  output  1  program finished (registered)
Err  output  1  memory timeout (registered, sticky)
State  output  3  current state encoding

Behaviour:
- State encoding is IDLE=0, FETCH=1, EXEC=2, MEM=3, WB=4, HALT=5, ERROR=6.
- On Reset_n low, the block enters IDLE asynchronously:
  - Done=0, Err=0, wait counter=0.
  - All combinational strobes are 0 whenever the state is IDLE and Start=0.
- Strobes are combinational from state and inputs. Done, Err and State are registered.
- IDLE: Start=1 → PCClr=1 this cycle, next state FETCH.
- FETCH: IRLoad=1 for one cycle, next state EXEC. Decoder inputs are valid from EXEC onward.
- EXEC: decisions are evaluated in this priority order.
  1. Ack=1 → next state HALT. No strobes; the PC does not advance.
  2. LoadInst=1 → MemReq=1, MemWe=0, next state MEM.
  3. MemWrEn=1 → MemReq=1, MemWe=1, next state MEM.
  4. Otherwise → RegWrStrobe=RegWrEn, PCEn=1, next state FETCH.
     - If BranchEn=1 and BranchTaken=1: PCLoad=1 and PCSel=Jump.
     - BranchEn=1 with BranchTaken=0 advances the PC by one.
- Wait counter:
  - Cleared on entry to MEM.
  - Increments each MEM cycle with MemReady=0.
  - Saturates at MEM_TIMEOUT.
- MEM: MemReq stays high and MemWe is held at the value chosen in EXEC.
  - MemReady=1 on a load → next state WB.
  - MemReady=1 on a store → PCEn=1, next state FETCH.
  - MemReady in the same cycle the counter reaches MEM_TIMEOUT counts as success; ready wins.
  - Counter equals MEM_TIMEOUT and MemReady=0 → next state ERROR, Err←1, MemReq drops.
  - An EXEC-to-MEM transition that sees MemReady=1 already in EXEC does not complete the access; completion is sampled only in MEM.
- WB: RegWrStrobe=1, PCEn=1, next state FETCH.
- Latencies:
  - ALU/branch instruction: 2 cycles.
  - Load: 4 cycles minimum.
  - Store: 3 cycles minimum.
- HALT: Done=1, held.
  - Start=1 → PCClr=1, Done←0, next state FETCH (restart).
- ERROR: Err=1 and Done=0, held.
  - Start=1 → Err←0, PCClr=1, next state FETCH.
- Start is ignored in FETCH, EXEC, MEM and WB.
- Reset_n asserted mid-operation (any state, including MEM with a request pending) drops MemReq immediately, asynchronously.
- Illegal state encodings (7) → IDLE on the next clock.

Optional Feature:
- Macro: PROG_SEQ_PERF_CNT_EN.
- When defined, adds output ports CycleCnt [CNT_W-1:0] and InstCnt [CNT_W-1:0], both reset to 0.
  - Both counters clear on any accepted Start.
  - CycleCnt increments every cycle the state is FETCH, EXEC, MEM or WB.
  - InstCnt increments on each instruction retirement, including Ack entering HALT.
  - Retirement means a transition out of EXEC to FETCH, out of MEM to FETCH, or out of WB.
  - Both counters saturate at all-ones and freeze in HALT/ERROR.
- When not defined, the ports and logic are absent. Behaviour is otherwise identical.

Test Plan:
- Reset, then Start pulse with an add instruction (RegWrEn=1) → PCClr in cycle 0; IRLoad in cycle 1; RegWrStrobe=1 and PCEn=1 in cycle 2; back in FETCH in cycle 3.
- Branch with BranchEn=1, Jump=1, BranchTaken=1 → EXEC shows PCEn=1, PCLoad=1, PCSel=1. Repeat with BranchTaken=0 → PCLoad=0.
- Load with MemReady asserted 3 cycles after MEM entry → MemReq high 3 cycles with MemWe=0, then WB with RegWrStrobe=1; load retires in 6 cycles.
- Store with MemReady never asserted, MEM_TIMEOUT=15 → Err=1 after 15 MEM cycles, MemReq=0, State=6. Then a Start pulse → Err=0 and State=FETCH.
- Ack instruction → State=HALT, Done=1, no PCEn. A Start pulse mid-program is ignored, while Start in HALT restarts with PCClr. With PROG_SEQ_PERF_CNT_EN defined and a 3-instruction program (add, store with 1-cycle ready, Ack), InstCnt=3 and CycleCnt=7.
- Reset_n pulled low during MEM → MemReq=0 immediately, State=IDLE, Done=0, Err=0.
